// File: rtl/c17_bist_pkg.sv
// Shared types and default constants for the c17 BIST response path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package c17_bist_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } c17_state_e;

  localparam logic [15:0] C17_MISR_POLY = 16'h1021;
  localparam logic [15:0] C17_MISR_SEED = 16'hFFFF;
  localparam int          C17_RESP_W    = 2;

endpackage

// File: rtl/c17_misr.sv
// Multiple-input signature register folding c17 responses into a signature.
// Latency: one cycle from en to updated sig.
// Backpressure: none; compacts on every cycle en is high.
module c17_misr
  import c17_bist_pkg::*;
#(
  parameter int               SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY  = C17_MISR_POLY,
  parameter logic [SIG_W-1:0] SEED  = C17_MISR_SEED
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  en,
  input  logic [C17_RESP_W-1:0] din,
  output logic [SIG_W-1:0]      sig
);

  logic [SIG_W-1:0] sig_next;
  logic [SIG_W-1:0] fb;

  // Left shift, polynomial feedback on the outgoing MSB, response into the low bits.
  always_comb begin
    fb       = sig[SIG_W-1] ? POLY : '0;
    sig_next = {sig[SIG_W-2:0], 1'b0} ^ fb ^ SIG_W'(din);
  end

  // Reseed has priority over compaction so a restart never folds in a stray beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      sig <= SEED;
    end else if (load) begin
      sig <= SEED;
    end else if (en) begin
      sig <= sig_next;
    end
  end

endmodule

// File: rtl/c17_response_compactor.sv
// Compacts c17 responses into a MISR, counts patterns, checks the final signature.
// Latency: one cycle from handshake to updated signature/pat_count; done lands with the last update.
// Backpressure: resp_ready is high for the whole of RUN (never stalls upstream), low otherwise.
module c17_response_compactor
  import c17_bist_pkg::*;
#(
  parameter int               SIG_W        = 16,
  parameter logic [SIG_W-1:0] POLY         = C17_MISR_POLY,
  parameter logic [SIG_W-1:0] SEED         = C17_MISR_SEED,
  parameter int               NUM_PATTERNS = 32,
  parameter logic [SIG_W-1:0] GOLDEN       = '0,
  localparam int              CNT_W        = $clog2(NUM_PATTERNS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  resp_valid,
  input  logic [C17_RESP_W-1:0] resp_data,
  output logic                  resp_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [SIG_W-1:0]      signature,
  output logic [CNT_W-1:0]      pat_count
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_PATTERNS - 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(NUM_PATTERNS);

  c17_state_e state;
  logic       accept;
  logic       reseed;

  // Handshake and restart qualifiers; start is only honoured outside RUN.
  always_comb begin
    resp_ready = (state == RUN);
    accept     = resp_valid && resp_ready;
    reseed     = start && (state != RUN);
  end

  // Status flags are pure functions of registered state, so they hold steady in DONE.
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
    pass = done && (signature == GOLDEN);
  end

  // Run-control FSM and saturating pattern counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pat_count <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= RUN;
            pat_count <= '0;
          end
        end
        RUN: begin
          if (accept) begin
            if (pat_count != MAX_CNT) begin
              pat_count <= pat_count + CNT_W'(1);
            end
            if (pat_count == LAST_IDX) begin
              state <= DONE;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  c17_misr #(
    .SIG_W (SIG_W),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_misr (
    .clk  (clk),
    .rst  (rst),
    .load (reseed),
    .en   (accept),
    .din  (resp_data),
    .sig  (signature)
  );

endmodule

// File: tb/tb_c17_response_compactor.sv
// Scoreboard bench: a short 2-pattern instance for directed signature checks
// and a default 32-pattern instance for reset-mid-run and full-length runs.
// Drivers push expectations; per-instance monitors pop them on each handshake.
module tb_c17_response_compactor;

  typedef struct {
    logic [15:0] sig;
    int          cnt;
    logic        dn;
    logic        ps;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // instance A: NUM_PATTERNS = 2, GOLDEN = CF9D
  logic        a_rst, a_start, a_valid, a_ready, a_busy, a_done, a_pass;
  logic [1:0]  a_data;
  logic [15:0] a_sig;
  logic [1:0]  a_cnt;

  // instance B: defaults (32 patterns, GOLDEN = 0000)
  logic        b_rst, b_start, b_valid, b_ready, b_busy, b_done, b_pass;
  logic [1:0]  b_data;
  logic [15:0] b_sig;
  logic [5:0]  b_cnt;

  exp_t q_a[$];
  exp_t q_b[$];
  logic [15:0] msig_b;

  c17_response_compactor #(
    .NUM_PATTERNS (2),
    .GOLDEN       (16'hCF9D)
  ) dut_a (
    .clk        (clk),
    .rst        (a_rst),
    .start      (a_start),
    .resp_valid (a_valid),
    .resp_data  (a_data),
    .resp_ready (a_ready),
    .busy       (a_busy),
    .done       (a_done),
    .pass       (a_pass),
    .signature  (a_sig),
    .pat_count  (a_cnt)
  );

  c17_response_compactor dut_b (
    .clk        (clk),
    .rst        (b_rst),
    .start      (b_start),
    .resp_valid (b_valid),
    .resp_data  (b_data),
    .resp_ready (b_ready),
    .busy       (b_busy),
    .done       (b_done),
    .pass       (b_pass),
    .signature  (b_sig),
    .pat_count  (b_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // bench-side MISR reference for the 32-pattern run
  function automatic logic [15:0] misr_model(input logic [15:0] s, input logic [1:0] d);
    logic [15:0] r;
    logic        msb;
    msb = s[15];
    r   = s << 1;
    if (msb) r = r ^ 16'h1021;
    r[1:0] = r[1:0] ^ d;
    return r;
  endfunction

  // monitors: one scoreboard pop per handshake, checked #1 after the edge
  always @(posedge clk) begin
    logic hs;
    hs = a_valid && a_ready;
    if (hs) begin
      #1;
      if (q_a.size() == 0) begin
        chk("a_unexpected_beat", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q_a.pop_front();
        chk("a_sig", 32'(a_sig), 32'(e.sig));
        chk("a_cnt", 32'(a_cnt), 32'(e.cnt));
        chk("a_done", 32'(a_done), 32'(e.dn));
        chk("a_pass", 32'(a_pass), 32'(e.ps));
      end
    end
  end

  always @(posedge clk) begin
    logic hs;
    hs = b_valid && b_ready;
    if (hs) begin
      #1;
      if (q_b.size() == 0) begin
        chk("b_unexpected_beat", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q_b.pop_front();
        chk("b_sig", 32'(b_sig), 32'(e.sig));
        chk("b_cnt", 32'(b_cnt), 32'(e.cnt));
        chk("b_done", 32'(b_done), 32'(e.dn));
        chk("b_pass", 32'(b_pass), 32'(e.ps));
      end
    end
  end

  task automatic start_a();
    @(negedge clk) a_start = 1'b1;
    @(negedge clk) a_start = 1'b0;
  endtask

  task automatic start_b();
    @(negedge clk) b_start = 1'b1;
    @(negedge clk) b_start = 1'b0;
  endtask

  task automatic beat_a(input logic [1:0] d, input logic [15:0] esig, input int ecnt,
                        input logic edn, input logic eps);
    exp_t e;
    e.sig = esig; e.cnt = ecnt; e.dn = edn; e.ps = eps;
    q_a.push_back(e);
    @(negedge clk) begin a_valid = 1'b1; a_data = d; end
    @(negedge clk) a_valid = 1'b0;
  endtask

  task automatic beat_b(input logic [1:0] d, input int ecnt, input logic edn);
    exp_t e;
    msig_b = misr_model(msig_b, d);
    e.sig = msig_b; e.cnt = ecnt; e.dn = edn; e.ps = edn && (msig_b == 16'h0000);
    q_b.push_back(e);
    @(negedge clk) begin b_valid = 1'b1; b_data = d; end
    @(negedge clk) b_valid = 1'b0;
  endtask

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    a_rst = 1'b1; a_start = 1'b0; a_valid = 1'b0; a_data = 2'b00;
    b_rst = 1'b1; b_start = 1'b0; b_valid = 1'b0; b_data = 2'b00;

    // 1: reset then idle
    repeat (2) @(posedge clk);
    @(negedge clk) begin a_rst = 1'b0; b_rst = 1'b0; end
    repeat (5) @(posedge clk);
    #1;
    chk("rst_sig", 32'(a_sig), 32'h0000FFFF);
    chk("rst_cnt", 32'(a_cnt), 32'd0);
    chk("rst_ready", 32'(a_ready), 32'd0);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_done", 32'(a_done), 32'd0);
    chk("rst_pass", 32'(a_pass), 32'd0);

    // 2: two-beat run matching golden
    start_a();
    chk("t2_busy", 32'(a_busy), 32'd1);
    chk("t2_ready", 32'(a_ready), 32'd1);
    beat_a(2'b01, 16'hEFDE, 1, 1'b0, 1'b0);
    beat_a(2'b00, 16'hCF9D, 2, 1'b1, 1'b1);
    chk("t2_ready_done", 32'(a_ready), 32'd0);
    chk("t2_busy_done", 32'(a_busy), 32'd0);
    // a beat offered in DONE must be ignored
    @(negedge clk) begin a_valid = 1'b1; a_data = 2'b11; end
    @(negedge clk) a_valid = 1'b0;
    chk("t2_hold_sig", 32'(a_sig), 32'h0000CF9D);
    chk("t2_hold_cnt", 32'(a_cnt), 32'd2);
    chk("t2_hold_pass", 32'(a_pass), 32'd1);

    // 3: mismatch
    start_a();
    chk("t3_reseed", 32'(a_sig), 32'h0000FFFF);
    chk("t3_clear", 32'(a_cnt), 32'd0);
    beat_a(2'b01, 16'hEFDE, 1, 1'b0, 1'b0);
    beat_a(2'b10, 16'hCF9F, 2, 1'b1, 1'b0);

    // 4: stall gaps
    start_a();
    beat_a(2'b01, 16'hEFDE, 1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t4_gap_sig", 32'(a_sig), 32'h0000EFDE);
      chk("t4_gap_cnt", 32'(a_cnt), 32'd1);
    end
    beat_a(2'b00, 16'hCF9D, 2, 1'b1, 1'b1);

    // 5: start ignored in RUN, honoured in DONE
    start_a();
    beat_a(2'b01, 16'hEFDE, 1, 1'b0, 1'b0);
    start_a();
    chk("t5_ign_sig", 32'(a_sig), 32'h0000EFDE);
    chk("t5_ign_cnt", 32'(a_cnt), 32'd1);
    chk("t5_ign_busy", 32'(a_busy), 32'd1);
    beat_a(2'b00, 16'hCF9D, 2, 1'b1, 1'b1);
    start_a();
    chk("t5_rs_sig", 32'(a_sig), 32'h0000FFFF);
    chk("t5_rs_cnt", 32'(a_cnt), 32'd0);
    chk("t5_rs_busy", 32'(a_busy), 32'd1);
    chk("t5_rs_done", 32'(a_done), 32'd0);

    // 6: reset mid-run on the 32-pattern instance
    msig_b = 16'hFFFF;
    start_b();
    beat_b(2'b01, 1, 1'b0);
    @(negedge clk) b_rst = 1'b1;
    @(negedge clk) b_rst = 1'b0;
    chk("t6_rst_sig", 32'(b_sig), 32'h0000FFFF);
    chk("t6_rst_cnt", 32'(b_cnt), 32'd0);
    chk("t6_rst_busy", 32'(b_busy), 32'd0);
    chk("t6_rst_ready", 32'(b_ready), 32'd0);
    // rst and start together: reset wins
    @(negedge clk) begin b_rst = 1'b1; b_start = 1'b1; end
    @(negedge clk) begin b_rst = 1'b0; b_start = 1'b0; end
    chk("t6_rstwin_busy", 32'(b_busy), 32'd0);
    // full 32-beat all-zero run
    msig_b = 16'hFFFF;
    start_b();
    for (int i = 0; i < 32; i++) begin
      beat_b(2'b00, i + 1, (i == 31));
    end
    chk("t6_done", 32'(b_done), 32'd1);
    chk("t6_cnt", 32'(b_cnt), 32'd32);
    chk("t6_ready", 32'(b_ready), 32'd0);

    repeat (2) @(negedge clk);
    chk("q_a_drained", 32'(q_a.size()), 32'd0);
    chk("q_b_drained", 32'(q_b.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
